// File: rtl/ff_synchroniser_nbit.sv
// ---------------------------------------------------------------------------
// ff_synchroniser_nbit
//
// Multi-bit clock-domain-crossing synchroniser. Each of WIDTH independent
// asynchronous level inputs passes through a STAGES-deep flop chain into the
// clk domain. The block then produces a clean level per bit plus one-cycle
// rise/fall pulses and a combined "changed" strobe.
//
// Optional feature, macro SYNC_FILTER_EN:
//   defined     - a per-bit glitch filter sits after the chain. A new level
//                 must hold for FILTER_CYCLES consecutive cycles before it
//                 reaches data_out. Latency is STAGES+FILTER_CYCLES edges.
//   not defined - no counters. data_out is the last synchroniser flop and
//                 the latency is STAGES edges.
//
// Parameters:
//   WIDTH         number of independent channels (1..32)
//   STAGES        synchroniser flops per channel (2..4)
//   FILTER_CYCLES stable cycles required by the filter (1..16)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   data_in   asynchronous level inputs, one per channel
//   data_out  synchronised (and filtered) levels
//   rise      one-cycle pulse when data_out[i] goes 0->1
//   fall      one-cycle pulse when data_out[i] goes 1->0
//   changed   OR-reduction of rise | fall
// ---------------------------------------------------------------------------
module ff_synchroniser_nbit #(
    parameter int WIDTH         = 8,
    parameter int STAGES        = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Out-of-range parameters stop elaboration.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("ff_synchroniser_nbit: WIDTH must be 1..32");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("ff_synchroniser_nbit: STAGES must be 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 16) begin : g_bad_filter
        $error("ff_synchroniser_nbit: FILTER_CYCLES must be 1..16");
    end

`ifdef SYNC_FILTER_EN
    // All STAGES flops are in the chain; data_out is a separate filtered
    // register behind the last one.
    localparam int CHAIN_LEN = STAGES;
`else
    // Without the filter, data_out is itself the last synchroniser flop.
    // The explicit chain therefore holds one fewer stage.
    localparam int CHAIN_LEN = STAGES - 1;
`endif

    // sync_q[0] is s1, the only flop allowed to go metastable. Nothing but
    // wire sits between chain stages, giving each stage a full cycle to
    // resolve.
    logic [WIDTH-1:0] sync_q [CHAIN_LEN];
    logic [WIDTH-1:0] sync_level;
    logic [WIDTH-1:0] next_out;

    // NOTE: the chain is a small array of flops, not a RAM. Clearing it on
    // reset discards stale samples, so no pulse can leak out after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < CHAIN_LEN; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of its predecessor. Blocking ones would collapse the chain.
            sync_q[0] <= data_in;
            for (int k = 1; k < CHAIN_LEN; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_level = sync_q[CHAIN_LEN-1];

`ifdef SYNC_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // The counter tracks how many consecutive edges the synchronised level
    // has disagreed with data_out. Any agreement restarts the count, so a
    // short glitch is discarded.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // forgot one would infer a latch.
        next_out = data_out;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_level[i] != data_out[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    next_out[i] = sync_level[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    assign next_out = sync_level;
`endif

    // The pulses are computed from next_out against the current data_out.
    // They therefore register on the same edge that data_out takes its new
    // value. A level cannot rise and fall at once, so rise and fall are
    // mutually exclusive per bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            rise     <= '0;
            fall     <= '0;
            changed  <= 1'b0;
        end else begin
            data_out <= next_out;
            rise     <= next_out & ~data_out;
            fall     <= ~next_out & data_out;
            changed  <= |(next_out ^ data_out);
        end
    end

endmodule

// File: tb/tb_ff_synchroniser_nbit.sv
// ---------------------------------------------------------------------------
// tb_ff_synchroniser_nbit
//
// Self-checking bench for ff_synchroniser_nbit. The reference model keeps a
// history of the data_in values captured at each edge. It derives the
// expected level from that history:
//   - unfiltered: the sample taken STAGES-1 edges ago.
//   - filtered:   the level flips once the last FILTER_CYCLES values seen at
//                 the chain output all differ from it.
// Pulses are derived from the old and new expected levels.
// ---------------------------------------------------------------------------
module tb_ff_synchroniser_nbit;

    localparam int WIDTH    = 8;
    localparam int P_STAGES = 2;
    localparam int P_FC     = 3;
`ifdef SYNC_FILTER_EN
    localparam int LAT = P_STAGES + P_FC;
`else
    localparam int LAT = P_STAGES;
`endif
    localparam int HL = P_STAGES + P_FC + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] data_in = '1;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    ff_synchroniser_nbit #(
        .WIDTH        (WIDTH),
        .STAGES       (P_STAGES),
        .FILTER_CYCLES(P_FC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .data_out(data_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // hist[0] holds the newest captured data_in value.
    logic [WIDTH-1:0] hist [HL];
    logic [WIDTH-1:0] m_out  = '0;
    logic [WIDTH-1:0] m_rise = '0;
    logic [WIDTH-1:0] m_fall = '0;

    task automatic model_edge(input logic [WIDTH-1:0] din, input logic rstv);
        logic [WIDTH-1:0] nxt;
        logic             all_diff;
        if (!rstv) begin
            for (int k = 0; k < HL; k++) hist[k] = '0;
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
        end else begin
            for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = din;
`ifdef SYNC_FILTER_EN
            nxt = m_out;
            for (int b = 0; b < WIDTH; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < P_FC; j++) begin
                    if (hist[P_STAGES + j][b] == m_out[b]) all_diff = 1'b0;
                end
                if (all_diff) nxt[b] = ~m_out[b];
            end
`else
            all_diff = 1'b0;
            nxt = hist[P_STAGES-1];
`endif
            m_rise = nxt & ~m_out;
            m_fall = ~nxt & m_out;
            m_out  = nxt;
        end
    endtask

    // One clock edge: capture the inputs, advance the model, then compare
    // the outputs on the following falling edge.
    task automatic tick(input string tag);
        logic [WIDTH-1:0] din;
        logic             rv;
        din = data_in;
        rv  = rst_n;
        @(posedge clk);
        model_edge(din, rv);
        @(negedge clk);
        check({tag, ".out"},  32'(data_out), 32'(m_out));
        check({tag, ".rise"}, 32'(rise),     32'(m_rise));
        check({tag, ".fall"}, 32'(fall),     32'(m_fall));
        check({tag, ".chg"},  32'(changed),  32'(|(m_rise | m_fall)));
    endtask

    // Count edges until data_out[bitn] goes high. The wait is bounded.
    task automatic measure(input string tag, input int bitn, output int edges);
        edges = -1;
        for (int i = 0; i < 64; i++) begin
            tick(tag);
            if (data_out[bitn]) begin
                edges = i + 1;
                break;
            end
        end
    endtask

    int  edges;
    logic glitch_seen;

    initial begin
        // Reset held for 3 edges with all inputs high.
        rst_n   = 1'b0;
        data_in = 8'hFF;
        for (int i = 0; i < 3; i++) tick("reset");
        rst_n   = 1'b1;
        data_in = 8'h00;
        tick("release");
        check("release.nopulse", 32'(changed), 32'd0);
        for (int i = 0; i < LAT + 2; i++) tick("settle");

        // Latency on bit 0.
        data_in = 8'h01;
        measure("lat", 0, edges);
        check("lat.edges", 32'(edges), 32'(LAT));
        check("lat.rise_on", 32'(rise[0]), 32'd1);
        tick("lat_after");
        check("lat.rise_off", 32'(rise[0]), 32'd0);

        // Two-cycle glitch on bit 3.
        glitch_seen = 1'b0;
        data_in = 8'h09;
        tick("glitch");
        tick("glitch");
        data_in = 8'h01;
        for (int i = 0; i < LAT + P_FC + 2; i++) begin
            tick("glitch_tail");
            if (data_out[3] || rise[3]) glitch_seen = 1'b1;
        end
`ifdef SYNC_FILTER_EN
        check("glitch.rejected", 32'(glitch_seen), 32'd0);
`endif

        // Sustained high on bit 3.
        data_in = 8'h09;
        measure("hold3", 3, edges);
        check("hold3.edges", 32'(edges), 32'(LAT));
        check("hold3.rise", 32'(rise[3]), 32'd1);

        // Multi-bit switch 0F -> F0.
        data_in = 8'h0F;
        for (int i = 0; i < LAT + 3; i++) tick("mb_pre");
        data_in = 8'hF0;
        for (int i = 0; i < LAT; i++) tick("mb");
        check("mb.rise", 32'(rise), 32'hF0);
        check("mb.fall", 32'(fall), 32'h0F);
        check("mb.chg",  32'(changed), 32'd1);
        tick("mb_after");
        check("mb.chg_off", 32'(changed), 32'd0);

        // Reset during a partial filter count.
        data_in = 8'h00;
        for (int i = 0; i < LAT + 3; i++) tick("rmf_pre");
        data_in = 8'h20;
        for (int i = 0; i < P_STAGES + 1; i++) tick("rmf_count");
        rst_n = 1'b0;
        tick("rmf_reset");
        check("rmf.cleared", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        measure("rmf", 5, edges);
        check("rmf.edges", 32'(edges), 32'(LAT));

        // Random holds of varying length, with occasional resets.
        for (int burst = 0; burst < 120; burst++) begin
            int hold;
            data_in = WIDTH'($urandom);
            hold    = int'($urandom_range(1, P_FC + 2));
            rst_n   = ($urandom_range(0, 24) != 0);
            for (int i = 0; i < hold; i++) begin
                tick("rand");
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
